key_debouncer: RTL and testbench



---
 rtl/key_debouncer.sv | 157 +++++++++++++++
 tb/tb_key_debouncer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/key_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : key_debouncer
//  Purpose  : Per-channel push-button conditioning. Each channel has a
//             2-FF synchronizer, a consecutive-sample debounce counter,
//             registered press/release strobes and a typematic step strobe
//             (one step on press, then auto-repeat while held).
//  Revision : 1.0 - initial release
// ============================================================================
module key_debouncer #(
  parameter int NUM_KEYS        = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys_raw,
  output logic [NUM_KEYS-1:0] keys_level,
  output logic [NUM_KEYS-1:0] keys_press,
  output logic [NUM_KEYS-1:0] keys_release,
  output logic [NUM_KEYS-1:0] keys_step
);

  // Debounce counter only has to reach N-1.
  localparam int c_CNT_W   = $clog2(DEBOUNCE_CYCLES);
  // Repeat counter is shared between the delay and period phases.
  localparam int c_RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int c_RPT_W   = $clog2(c_RPT_MAX);

  localparam logic [c_CNT_W-1:0] c_CNT_LAST   = c_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_RPT_W-1:0] c_DELAY_LAST = c_RPT_W'(REPEAT_DELAY - 1);
  localparam logic [c_RPT_W-1:0] c_PER_LAST   = c_RPT_W'(REPEAT_PERIOD - 1);

  // Polarity fold: after this, 1 always means "pressed".
  localparam logic [NUM_KEYS-1:0] c_POL_MASK = (ACTIVE_LOW != 0) ? {NUM_KEYS{1'b1}} : {NUM_KEYS{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_t;

  logic [NUM_KEYS-1:0] w_norm;
  assign w_norm = keys_raw ^ c_POL_MASK;

  generate
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      logic               r_sync1;
      logic               r_sync2;
      logic [c_CNT_W-1:0] r_cnt;
      logic               r_level;
      logic               r_press;
      logic               r_release;
      logic [c_RPT_W-1:0] r_rcnt;
      rpt_state_t         r_state;
      logic               r_step;

      logic w_accept;
      logic w_rise;
      logic w_fall;

      // A new state is accepted on the N-th consecutive disagreeing sample.
      assign w_accept = (r_sync2 != r_level) && (r_cnt == c_CNT_LAST);
      assign w_rise   = w_accept &  r_sync2;
      assign w_fall   = w_accept & ~r_sync2;

      // Two-stage synchronizer; resets to "not pressed" so a key held
      // through reset is seen as a fresh press afterwards.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
        end else begin
          r_sync1 <= w_norm[k];
          r_sync2 <= r_sync1;
        end
      end

      // Consecutive-sample debounce; any agreeing sample restarts the count.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_cnt     <= '0;
          r_level   <= 1'b0;
          r_press   <= 1'b0;
          r_release <= 1'b0;
        end else begin
          r_press   <= w_rise;
          r_release <= w_fall;
          if (r_sync2 == r_level) begin
            r_cnt <= '0;
          end else if (r_cnt == c_CNT_LAST) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      // Typematic repeat: step on press, after DELAY, then every PERIOD.
      // A falling level wins over a coincident terminal count.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_state <= ST_IDLE;
          r_rcnt  <= '0;
          r_step  <= 1'b0;
        end else begin
          r_step <= 1'b0;
          if (w_fall) begin
            r_state <= ST_IDLE;
            r_rcnt  <= '0;
          end else begin
            case (r_state)
              ST_IDLE: begin
                if (w_rise) begin
                  r_step  <= 1'b1;
                  r_rcnt  <= '0;
                  r_state <= ST_DELAY;
                end
              end
              ST_DELAY: begin
                if (r_rcnt == c_DELAY_LAST) begin
                  r_step  <= 1'b1;
                  r_rcnt  <= '0;
                  r_state <= ST_REPEAT;
                end else begin
                  r_rcnt <= r_rcnt + 1'b1;
                end
              end
              ST_REPEAT: begin
                if (r_rcnt == c_PER_LAST) begin
                  r_step <= 1'b1;
                  r_rcnt <= '0;
                end else begin
                  r_rcnt <= r_rcnt + 1'b1;
                end
              end
              default: begin
                r_state <= ST_IDLE;
                r_rcnt  <= '0;
              end
            endcase
          end
        end
      end

      assign keys_level[k]   = r_level;
      assign keys_press[k]   = r_press;
      assign keys_release[k] = r_release;
      assign keys_step[k]    = r_step;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_key_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_debouncer
//  Purpose  : Self-checking bench for key_debouncer (N=4, D=6, R=3), with an
//             active-low and an active-high instance side by side.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_key_debouncer;

  localparam int N = 4;
  localparam int D = 6;
  localparam int R = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] raw_a;   // active-low instance
  logic [3:0] raw_b;   // active-high instance
  logic [3:0] lvl_a, prs_a, rel_a, stp_a;
  logic [3:0] lvl_b, prs_b, rel_b, stp_b;

  int total = 0;
  int bad   = 0;
  bit en    = 1'b0;

  always #5 clk = ~clk;

  key_debouncer #(
    .NUM_KEYS(4), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(N),
    .REPEAT_DELAY(D), .REPEAT_PERIOD(R)
  ) u_dut_al (
    .clk(clk), .reset(reset), .keys_raw(raw_a),
    .keys_level(lvl_a), .keys_press(prs_a),
    .keys_release(rel_a), .keys_step(stp_a)
  );

  key_debouncer #(
    .NUM_KEYS(4), .ACTIVE_LOW(0), .DEBOUNCE_CYCLES(N),
    .REPEAT_DELAY(D), .REPEAT_PERIOD(R)
  ) u_dut_ah (
    .clk(clk), .reset(reset), .keys_raw(raw_b),
    .keys_level(lvl_b), .keys_press(prs_b),
    .keys_release(rel_b), .keys_step(stp_b)
  );

  // ---------------- behavioural model (channels 0-3: a, 4-7: b) ----------
  // Level flips once the last N samples seen after the synchronizer all
  // disagree with it. Steps fire at P, P+D, P+D+R, ... while held.
  bit         s1[8], s2[8], lvl[8], e_prs[8], e_rel[8], e_stp[8];
  bit [N-1:0] win[8];
  int         wlen[8];
  int         pe[8];
  int         ecnt = 0;

  task automatic cmp(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %b want %b", nm, $time, act, exp);
    end
  endtask

  always begin
    logic [3:0] xl_a, xp_a, xr_a, xs_a, xl_b, xp_b, xr_b, xs_b;
    @(posedge clk);
    for (int c = 0; c < 8; c++) begin
      bit nrm, seen, flip;
      nrm = (c < 4) ? ~raw_a[c] : raw_b[c-4];
      if (reset) begin
        s1[c] = 0; s2[c] = 0; lvl[c] = 0; win[c] = '0; wlen[c] = 0;
        e_prs[c] = 0; e_rel[c] = 0; e_stp[c] = 0; pe[c] = 0;
      end else begin
        seen  = s2[c];
        s2[c] = s1[c];
        s1[c] = nrm;
        win[c] = {win[c][N-2:0], seen};
        if (wlen[c] < N) wlen[c]++;
        flip = (wlen[c] == N) && (win[c] == {N{~lvl[c]}});
        e_prs[c] = flip && !lvl[c];
        e_rel[c] = flip &&  lvl[c];
        if (flip) begin
          lvl[c]  = ~lvl[c];
          wlen[c] = 0;
        end
        if (e_prs[c]) pe[c] = ecnt;
        e_stp[c] = lvl[c] && (e_prs[c] ||
                   ((ecnt - pe[c]) >= D && ((ecnt - pe[c] - D) % R) == 0));
      end
    end
    ecnt++;
    #1;
    for (int c = 0; c < 4; c++) begin
      xl_a[c] = lvl[c];   xp_a[c] = e_prs[c];   xr_a[c] = e_rel[c];   xs_a[c] = e_stp[c];
      xl_b[c] = lvl[c+4]; xp_b[c] = e_prs[c+4]; xr_b[c] = e_rel[c+4]; xs_b[c] = e_stp[c+4];
    end
    if (en) begin
      cmp("model level_a",   lvl_a, xl_a);
      cmp("model press_a",   prs_a, xp_a);
      cmp("model release_a", rel_a, xr_a);
      cmp("model step_a",    stp_a, xs_a);
      cmp("model level_b",   lvl_b, xl_b);
      cmp("model press_b",   prs_b, xp_b);
      cmp("model release_b", rel_b, xr_b);
      cmp("model step_b",    stp_b, xs_b);
    end
  end

  // ---------------- directed stimulus with literal expectations ----------
  // adv(n): move to just after the n-th next rising edge.
  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    raw_a = 4'hF;
    raw_b = 4'b0001;   // b key 0 held high from power-up
    adv(1);
    en = 1'b1;
    adv(2);
    cmp("reset level_a", lvl_a, 4'b0000);
    cmp("reset press_a", prs_a, 4'b0000);
    cmp("reset press_b", prs_b, 4'b0000);
    reset = 1'b0;

    // 1. Clean press on key 0; b key 0 is detected at the same edge.
    raw_a[0] = 1'b0;
    adv(5);
    cmp("t1 level before edge5", lvl_a, 4'b0000);
    adv(1);
    cmp("t1 level edge5", lvl_a, 4'b0001);
    cmp("t1 press edge5", prs_a, 4'b0001);
    cmp("t1 step edge5",  stp_a, 4'b0001);
    cmp("t6 powerup press_b", prs_b, 4'b0001);
    cmp("t6 powerup rel_b",   rel_b, 4'b0000);
    adv(1);
    cmp("t1 press one cycle", prs_a, 4'b0000);

    // 2. Short glitch is rejected; bounce then settle.
    raw_a[1] = 1'b0; adv(3);
    raw_a[1] = 1'b1; adv(10);
    cmp("t2 glitch level", lvl_a, 4'b0001);
    raw_a[1] = 1'b0; adv(1);
    raw_a[1] = 1'b1; adv(1);
    raw_a[1] = 1'b0; adv(1);
    raw_a[1] = 1'b1; adv(1);
    raw_a[1] = 1'b0; adv(5);
    cmp("t2 bounce before", lvl_a, 4'b0001);
    adv(1);
    cmp("t2 bounce settle", lvl_a, 4'b0011);
    raw_a = 4'hF; adv(8);
    cmp("t2 all released", lvl_a, 4'b0000);

    // 3. Auto-repeat on key 2, release on a terminal count.
    raw_a[2] = 1'b0; adv(6);
    cmp("t3 step P",    stp_a, 4'b0100);
    adv(6);
    cmp("t3 step P+6",  stp_a, 4'b0100);
    adv(1);
    cmp("t3 step P+7",  stp_a, 4'b0000);
    adv(2);
    cmp("t3 step P+9",  stp_a, 4'b0100);
    adv(3);
    cmp("t3 step P+12", stp_a, 4'b0100);
    raw_a[2] = 1'b1; adv(6);    // level falls at P+18, a terminal count
    cmp("t3 rel P+18",  rel_a, 4'b0100);
    cmp("t3 nostep P+18", stp_a, 4'b0000);
    adv(10);

    // 4. All four pressed together; keys 0 and 3 released 2 apart.
    raw_a = 4'h0; adv(6);
    cmp("t4 press all", prs_a, 4'b1111);
    adv(4);
    raw_a[0] = 1'b1; adv(2);
    raw_a[3] = 1'b1; adv(4);
    cmp("t4 rel key0", rel_a, 4'b0001);
    adv(2);
    cmp("t4 rel key3", rel_a, 4'b1000);
    raw_a = 4'hF; adv(8);

    // 5. Reset while key 0's debounce count is at 2.
    raw_a[0] = 1'b0; adv(4);
    reset = 1'b1; adv(1);
    cmp("t5 reset level_a", lvl_a, 4'b0000);
    cmp("t5 reset press_a", prs_a, 4'b0000);
    cmp("t5 reset level_b", lvl_b, 4'b0000);
    adv(2);
    reset = 1'b0;
    adv(5);
    cmp("t5 before edge5", lvl_a, 4'b0000);
    adv(1);
    cmp("t5 press edge5",  prs_a, 4'b0001);
    cmp("t5 no release",   rel_a, 4'b0000);
    cmp("t5 press_b held", prs_b, 4'b0001);
    raw_a = 4'hF; adv(8);

    // 6. Active-high instance: raw 0->1 on key 1.
    raw_b[1] = 1'b1; adv(5);
    cmp("t6 before edge5", lvl_b & 4'b0010, 4'b0000);
    adv(1);
    cmp("t6 press edge5", prs_b, 4'b0010);
    adv(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
